des_decrypt_iter: RTL



---
 rtl/des_pkg.sv | 140 ++++++++++++++
 rtl/des_f.sv | 20 ++
 rtl/des_decrypt_iter.sv | 106 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES tables and helpers (permutations, rotates, S-boxes, key parity).
// Imported by the iterative decryptor, the f-function and the encryptor.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int ROUNDS = 16;

  // Right-rotate amounts that walk the key schedule backwards, K16 first.
  localparam int SHIFT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Flattened S-boxes: index = box*64 + row*16 + column.
  localparam int SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  // Tables use FIPS numbering: bit 1 is the MSB of the input word.
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [3:0] sbox(input int box, input logic [5:0] b);
    int idx;
    idx = box * 64 + 16 * int'({b[5], b[0]}) + int'(b[4:1]);
    return 4'(SBOX[idx]);
  endfunction

  // DES key bytes must have odd parity; flag any byte that does not.
  function automatic logic key_parity_err(input logic [63:0] key);
    logic err;
    err = 1'b0;
    for (int i = 0; i < 8; i++) if (!(^key[8*i +: 8])) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f_out
);

  logic [47:0] mixed;
  logic [31:0] sub;

  always_comb begin
    mixed = e_expand(r) ^ subkey;
    sub   = '0;
    for (int b = 0; b < 8; b++) sub[31-4*b -: 4] = sbox(b, mixed[47-6*b -: 6]);
    f_out = p_perm(sub);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor, one Feistel round per clock over 16 clocks.
// Optional key parity flag (KEY_ERR) enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [63:0] CIPHER_TEXT,
  input  logic [63:0] KEY,
  output logic [63:0] PLAIN_TEXT,
  output logic        BUSY,
  output logic        DONE
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        KEY_ERR
`endif
);

  state_t      state, state_next;
  logic [3:0]  rnd;
  logic [31:0] l, r;
  logic [27:0] c, d;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_val;
  logic [31:0] r_next;
  logic        accept;
  logic        last_round;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_round = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (rnd == 4'd15) begin
          last_round = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign BUSY = (state == RUN);

  // Right rotation undoes the encryptor's left shifts, so subkeys come out K16..K1.
  always_comb begin
    c_rot  = rotr28(c, SHIFT_DEC[rnd]);
    d_rot  = rotr28(d, SHIFT_DEC[rnd]);
    subkey = pc2({c_rot, d_rot});
    r_next = l ^ f_val;
  end

  des_f u_f (
    .r      (r),
    .subkey (subkey),
    .f_out  (f_val)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rnd        <= '0;
      l          <= '0;
      r          <= '0;
      c          <= '0;
      d          <= '0;
      PLAIN_TEXT <= '0;
      DONE       <= 1'b0;
    end else begin
      DONE <= last_round;
      if (accept) begin
        {l, r} <= ip(CIPHER_TEXT);
        {c, d} <= pc1(KEY);
        rnd    <= '0;
      end else if (state == RUN) begin
        c   <= c_rot;
        d   <= d_rot;
        l   <= r;
        r   <= r_next;
        rnd <= rnd + 4'd1;
        // Output takes {R16, L16}: the final half swap is undone here.
        if (last_round) PLAIN_TEXT <= fp({r_next, r});
      end
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      KEY_ERR <= 1'b0;
    else if (accept) KEY_ERR <= key_parity_err(KEY);
  end
`endif

endmodule
